// File: rtl/alu_arbiter_if.sv
// Bus bundle for alu_arbiter: requester, response and shared-ALU signal groups.
// The req_lock group exists only when ALU_ARB_LOCK_EN is defined.
interface alu_arbiter_if #(
  parameter int NREQ = 3,
  parameter int W    = 8
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*3-1:0] req_cmd;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sc;
`ifdef ALU_ARB_LOCK_EN
  logic [NREQ-1:0]   req_lock;
`endif

  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic              rsp_ready;
  logic [W-1:0]      rsp_rslt;
  logic              rsp_sc;
  logic              rsp_pari;
  logic              rsp_zero;

  logic [2:0]        alu_cmd;
  logic [W-1:0]      alu_inA;
  logic [W-1:0]      alu_inB;
  logic              alu_sc_i;
  logic [W-1:0]      alu_rslt;
  logic              alu_sc_o;
  logic              alu_pari;
  logic              alu_zero;

  modport slave (
`ifdef ALU_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req_valid, req_cmd, req_a, req_b, req_sc,
    output req_ready,
    output rsp_valid, rsp_id, rsp_rslt, rsp_sc, rsp_pari, rsp_zero,
    input  rsp_ready,
    output alu_cmd, alu_inA, alu_inB, alu_sc_i,
    input  alu_rslt, alu_sc_o, alu_pari, alu_zero
  );

  modport master (
`ifdef ALU_ARB_LOCK_EN
    output req_lock,
`endif
    output req_valid, req_cmd, req_a, req_b, req_sc,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_rslt, rsp_sc, rsp_pari, rsp_zero,
    output rsp_ready,
    input  alu_cmd, alu_inA, alu_inB, alu_sc_i,
    output alu_rslt, alu_sc_o, alu_pari, alu_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU among NREQ requesters.
// Optional macro ALU_ARB_LOCK_EN adds req_lock: a locked requester keeps the ALU.
module alu_arbiter #(
  parameter int NREQ = 3,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]   win;
  logic            grant;
  logic [NREQ-1:0] ready_vec;

  logic [2:0]      cmd_arr [NREQ];
  logic [W-1:0]    a_arr   [NREQ];
  logic [W-1:0]    b_arr   [NREQ];

  logic [2:0]      cmd_p0;
  logic [W-1:0]    a_p0;
  logic [W-1:0]    b_p0;
  logic            sc_p0;
  logic [PW-1:0]   id_p0;

  logic            vld_p1;
  logic [PW-1:0]   id_p1;
  logic [W-1:0]    rslt_p1;
  logic            sc_p1;
  logic            pari_p1;
  logic            zero_p1;

`ifdef ALU_ARB_LOCK_EN
  logic            lock_pend, lock_pend_nxt;
  logic            lock_win;
`endif

  // First set bit at or above ptr, otherwise the lowest set bit (wrap-around).
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [PW-1:0]   ptr);
    logic [NREQ-1:0] sh;
    logic            hi_hit;
    logic [PW-1:0]   hi_w;
    logic [PW-1:0]   lo_w;
    hi_hit = 1'b0;
    hi_w   = '0;
    lo_w   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      sh = v >> j;
      if (sh[0]) begin
        lo_w = PW'(j);
        if (j >= int'(ptr)) begin
          hi_hit = 1'b1;
          hi_w   = PW'(j);
        end
      end
    end
    return hi_hit ? hi_w : lo_w;
  endfunction

  genvar g;
  for (g = 0; g < NREQ; g++) begin : g_unpack
    assign cmd_arr[g] = bus.req_cmd[g*3 +: 3];
    assign a_arr[g]   = bus.req_a[g*W +: W];
    assign b_arr[g]   = bus.req_b[g*W +: W];
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant      = 1'b0;
    win        = rr_pick(bus.req_valid, rr_ptr);
`ifdef ALU_ARB_LOCK_EN
    lock_pend_nxt = lock_pend;
    lock_win      = lock_pend && bus.req_valid[id_p0];
    if (lock_win) win = id_p0;
`endif
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
`ifdef ALU_ARB_LOCK_EN
          lock_pend_nxt = 1'b0;
          if (!lock_win)
            rr_ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
`else
          rr_ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
        end
      end
      ISSUE: state_nxt = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
`ifdef ALU_ARB_LOCK_EN
          lock_pend_nxt = bus.req_lock[id_p0] && bus.req_valid[id_p0];
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accept pulse is masked during reset so nothing looks granted while the core is held.
  always_comb begin
    ready_vec = '0;
    if (grant && !reset) ready_vec[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
`ifdef ALU_ARB_LOCK_EN
      lock_pend <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
`ifdef ALU_ARB_LOCK_EN
      lock_pend <= lock_pend_nxt;
`endif
    end
  end

  // Stage p0: winner's operands captured at accept, held while the ALU evaluates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_p0 <= '0;
      a_p0   <= '0;
      b_p0   <= '0;
      sc_p0  <= 1'b0;
      id_p0  <= '0;
    end else if (grant) begin
      cmd_p0 <= cmd_arr[win];
      a_p0   <= a_arr[win];
      b_p0   <= b_arr[win];
      sc_p0  <= bus.req_sc[win];
      id_p0  <= win;
    end
  end

  // Stage p1: ALU result and flags registered at the end of ISSUE, held through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      id_p1   <= '0;
      rslt_p1 <= '0;
      sc_p1   <= 1'b0;
      pari_p1 <= 1'b0;
      zero_p1 <= 1'b0;
    end else if (state == ISSUE) begin
      vld_p1  <= 1'b1;
      id_p1   <= id_p0;
      rslt_p1 <= bus.alu_rslt;
      sc_p1   <= bus.alu_sc_o;
      pari_p1 <= bus.alu_pari;
      zero_p1 <= bus.alu_zero;
    end else if (state == RESP && bus.rsp_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.alu_cmd   = cmd_p0;
  assign bus.alu_inA   = a_p0;
  assign bus.alu_inB   = b_p0;
  assign bus.alu_sc_i  = sc_p0;
  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_id    = 3'(id_p1);
  assign bus.rsp_rslt  = rslt_p1;
  assign bus.rsp_sc    = sc_p1;
  assign bus.rsp_pari  = pari_p1;
  assign bus.rsp_zero  = zero_p1;

endmodule
